// File: rtl/mac_serial2d_pkg.sv
// Shared types, default sizing and helpers for the self-sequenced 2D digit-serial MAC.
package mac_serial2d_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ACCU = 2'd2
  } mac_state_e;

  localparam int DEF_MAX_BITS = 32'd8;
  localparam int DEF_DIGIT    = 32'd2;
  localparam int DEF_ACC_W    = 32'd20;

  function automatic int unsigned num_digits(input int unsigned prec);
    return prec + 32'd1;
  endfunction

endpackage

// File: rtl/mac_serial2d_digit_pe.sv
// DIGIT x DIGIT digit multiplier (weight digit optionally signed) aligned into the
// 2*MAX_BITS product domain; arithmetic is modulo 2^(2*MAX_BITS).
module mac_serial2d_digit_pe
  import mac_serial2d_pkg::*;
#(
  parameter int MAX_BITS = DEF_MAX_BITS,
  parameter int DIGIT    = DEF_DIGIT,
  parameter int POS_W    = 32'd3
) (
  input  logic [DIGIT-1:0]      w_dig_i,
  input  logic [DIGIT-1:0]      a_dig_i,
  input  logic                  w_signed_i,
  input  logic [POS_W-1:0]      pos_i,
  output logic [2*MAX_BITS-1:0] pp_o
);

  localparam int PROD_W = 2 * MAX_BITS;

  logic [PROD_W-1:0] w_ext_s;
  logic [PROD_W-1:0] a_ext_s;
  logic [PROD_W-1:0] prod_s;

  // Extend both digits to product width, multiply, then align to digit position.
  always_comb begin
    if (w_signed_i) begin
      w_ext_s = {{(PROD_W-DIGIT){w_dig_i[DIGIT-1]}}, w_dig_i};
    end else begin
      w_ext_s = {{(PROD_W-DIGIT){1'b0}}, w_dig_i};
    end
    a_ext_s = {{(PROD_W-DIGIT){1'b0}}, a_dig_i};
    prod_s  = w_ext_s * a_ext_s;
    pp_o    = prod_s << (pos_i * DIGIT);
  end

endmodule

// File: rtl/mac_serial2d_seq.sv
// Self-sequenced 2D multi-bit-serial MAC with valid/ready on both sides.
// Optional build macro: MAC_SERIAL2D_SAT_EN (saturating accumulation instead of wrap).
module mac_serial2d_seq
  import mac_serial2d_pkg::*;
#(
  parameter int MAX_BITS = DEF_MAX_BITS,
  parameter int DIGIT    = DEF_DIGIT,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int PW       = $clog2(MAX_BITS / DIGIT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_BITS-1:0] w,
  input  logic [MAX_BITS-1:0] a,
  input  logic [PW-1:0]       w_prec,
  input  logic [PW-1:0]       a_prec,
  input  logic                acc_clr,
  input  logic                acc_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    z
);

  localparam int PROD_W = 2 * MAX_BITS;

  mac_state_e          state_q, state_d;
  logic [MAX_BITS-1:0] w_q, w_d, a_q, a_d;
  logic [PW-1:0]       wp_q, wp_d, ap_q, ap_d;
  logic [PW-1:0]       i_q, i_d, j_q, j_d;
  logic                clr_q, clr_d, last_q, last_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [ACC_W-1:0]    acc_q, acc_d, z_q, z_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;

  logic [PW:0]         pos_s;
  logic                w_sign_s;
  logic [PROD_W-1:0]   pp_s;
  logic [ACC_W-1:0]    prod_ext_s, acc_base_s, acc_sum_s;

  assign pos_s    = {1'b0, i_q} + {1'b0, j_q};
  assign w_sign_s = ((32'(j_q) + 32'd1) == num_digits(32'(wp_q)));

  mac_serial2d_digit_pe #(
    .MAX_BITS (MAX_BITS),
    .DIGIT    (DIGIT),
    .POS_W    (PW + 1)
  ) u_pe (
    .w_dig_i    (w_q[j_q*DIGIT +: DIGIT]),
    .a_dig_i    (a_q[i_q*DIGIT +: DIGIT]),
    .w_signed_i (w_sign_s),
    .pos_i      (pos_s),
    .pp_o       (pp_s)
  );

`ifdef MAC_SERIAL2D_SAT_EN
  logic [ACC_W:0] acc_wide_s;
`endif

  // Accumulator adder: optional clear, sign-extended product, wrap or saturate.
  always_comb begin
    prod_ext_s = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    if (clr_q) begin
      acc_base_s = '0;
    end else begin
      acc_base_s = acc_q;
    end
`ifdef MAC_SERIAL2D_SAT_EN
    acc_wide_s = {acc_base_s[ACC_W-1], acc_base_s} + {prod_ext_s[ACC_W-1], prod_ext_s};
    if (acc_wide_s[ACC_W] != acc_wide_s[ACC_W-1]) begin
      if (acc_wide_s[ACC_W]) begin
        acc_sum_s = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        acc_sum_s = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      acc_sum_s = acc_wide_s[ACC_W-1:0];
    end
`else
    acc_sum_s = acc_base_s + prod_ext_s;
`endif
  end

  // Sequencer: operand capture, digit-pair walk (weight inner), accumulate, output hold.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    a_d         = a_q;
    wp_d        = wp_q;
    ap_d        = ap_q;
    i_d         = i_q;
    j_d         = j_q;
    clr_d       = clr_q;
    last_d      = last_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          w_d     = w;
          a_d     = a;
          wp_d    = w_prec;
          ap_d    = a_prec;
          clr_d   = acc_clr;
          last_d  = acc_last;
          prod_d  = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MULT;
        end else begin
          state_d = IDLE;
        end
      end
      MULT: begin
        prod_d = prod_q + pp_s;
        if (j_q == wp_q) begin
          j_d = '0;
          if (i_q == ap_q) begin
            i_d     = '0;
            state_d = ACCU;
          end else begin
            i_d = i_q + PW'(1'b1);
          end
        end else begin
          j_d = j_q + PW'(1'b1);
        end
      end
      ACCU: begin
        acc_d = acc_sum_s;
        if (last_q) begin
          z_d         = acc_sum_s;
          out_valid_d = 1'b1;
        end else begin
          z_d = z_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE) && !out_valid_d;
  end

  // State and datapath registers; reset discards any in-flight operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      a_q         <= '0;
      wp_q        <= '0;
      ap_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      clr_q       <= 1'b0;
      last_q      <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      a_q         <= a_d;
      wp_q        <= wp_d;
      ap_q        <= ap_d;
      i_q         <= i_d;
      j_q         <= j_d;
      clr_q       <= clr_d;
      last_q      <= last_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z         = z_q;

endmodule
